imem_pipe: RTL and testbench

Parametrised, pipelined instruction memory for the RISC-V fetch stage. It replaces a purely combinational byte-array ROM with word-organised storage, a configurable read latency, a valid/ready request/response handshake with backpressure, and a flush. It also reports misaligned and out-of-range fetches. It sits between the PC/fetch unit and the decode stage.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_pipe_if.sv | 29 ++
 rtl/imem_bank.sv | 39 +++
 rtl/imem_pipe.sv | 123 ++++++++++++
 tb/tb_imem_pipe.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the pipelined instruction memory.
//   - rsp_err encodings (IMEM_OK / IMEM_MISALIGNED / IMEM_OOR)
//   - LATENCY_MAX: deepest supported read pipeline
//   - ofs_w(): number of byte-offset bits in a DATA_W-bit word
package imem_pkg;

    typedef enum logic [1:0] {
        IMEM_OK         = 2'b00,
        IMEM_MISALIGNED = 2'b01,
        IMEM_OOR        = 2'b10
    } imem_err_e;

    localparam int LATENCY_MAX = 4;

    function automatic int ofs_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/imem_pipe_if.sv
// imem_pipe_if: fetch request/response channel between the fetch unit
// (master) and the instruction memory (slave).
//   req_valid/req_ready/req_addr : byte-addressed fetch request
//   flush                        : kill all in-flight fetches
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data/rsp_err             : instruction word and status
interface imem_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_err;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_bank.sv
// imem_bank: word-organised instruction storage.
//   clk        : clock
//   ren/raddr  : synchronous read; rdata holds when ren is low
//   rdata      : registered read word
//   we/waddr/wdata/wstrb : byte-strobed write (only with IMEM_WRITE_PORT_EN)
// A same-edge read and write of one word return the old contents.
// Contents are never reset; they are loaded through the write port or
// preloaded by the environment.
module imem_bank #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 262144,
    parameter int    AW        = 18,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              ren,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
`ifdef IMEM_WRITE_PORT_EN
    ,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb
`endif
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ren) rdata <= mem[raddr];
`ifdef IMEM_WRITE_PORT_EN
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
`endif
    end
endmodule

// File: rtl/imem_pipe.sv
// imem_pipe: pipelined instruction memory for the fetch stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imem_pipe_if slave (request, flush, response)
//   wr_*       : strobed program-load port, present only when the
//                IMEM_WRITE_PORT_EN macro is defined
// Stage 0 is the bank's read register; stages 1..LATENCY-1 are delay
// registers; the last stage drives the response. A stalled response
// freezes every stage, flush clears every valid bit on the next edge.
module imem_pipe
    import imem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 32,
    parameter int    DEPTH     = 262144,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = "verilog/bin/imem.hex"
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef IMEM_WRITE_PORT_EN
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_strb,
`endif
    imem_pipe_if.slave          bus
);
    localparam int                OFS      = ofs_w(DATA_W);
    localparam int                IW       = ADDR_W - OFS;
    localparam int                BANK_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(DATA_W / 8 - 1);
    localparam logic [IW:0]       DEPTH_W  = (IW + 1)'(DEPTH);

    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("imem_pipe: LATENCY out of range");
    end

    logic                        stall;
    logic                        rd_en;
    logic [IW-1:0]               rd_idx;
    imem_err_e                   addr_err;
    logic [DATA_W-1:0]           rd_data;
    logic [DATA_W-1:0]           s0_data;
    logic [LATENCY-1:0]          vld_pipe;
    logic [LATENCY-1:0][1:0]     err_pipe;

    assign stall         = vld_pipe[LATENCY-1] && !bus.rsp_ready;
    assign bus.req_ready = !stall && !bus.flush;
    assign bus.rsp_valid = vld_pipe[LATENCY-1];
    assign bus.rsp_err   = err_pipe[LATENCY-1];

    // Misaligned takes precedence over out-of-range.
    assign rd_idx = bus.req_addr[ADDR_W-1:OFS];
    always_comb begin
        addr_err = IMEM_OK;
        if ((bus.req_addr & OFS_MASK) != '0)  addr_err = IMEM_MISALIGNED;
        else if ({1'b0, rd_idx} >= DEPTH_W)   addr_err = IMEM_OOR;
    end

    // Only good, accepted fetches touch the array, so the read register
    // keeps its word through a stall.
    assign rd_en = bus.req_valid && bus.req_ready && (addr_err == IMEM_OK);

`ifdef IMEM_WRITE_PORT_EN
    logic [IW-1:0] wr_idx;
    logic          wr_ok;
    assign wr_idx = wr_addr[ADDR_W-1:OFS];
    assign wr_ok  = wr_en && ((wr_addr & OFS_MASK) == '0) && ({1'b0, wr_idx} < DEPTH_W);
`endif

    imem_bank #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AW        (BANK_AW),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk   (clk),
        .ren   (rd_en),
        .raddr (rd_idx[BANK_AW-1:0]),
        .rdata (rd_data)
`ifdef IMEM_WRITE_PORT_EN
        ,
        .we    (wr_ok),
        .waddr (wr_idx[BANK_AW-1:0]),
        .wdata (wr_data),
        .wstrb (wr_strb)
`endif
    );

    // Error responses and empty slots read as zero.
    assign s0_data = (vld_pipe[0] && err_pipe[0] == IMEM_OK) ? rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
        end else if (bus.flush) begin
            vld_pipe <= '0;
        end else if (!stall) begin
            vld_pipe[0] <= bus.req_valid;
            err_pipe[0] <= addr_err;
            for (int k = 1; k < LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                err_pipe[k] <= err_pipe[k-1];
            end
        end
    end

    if (LATENCY == 1) begin : g_out_s0
        assign bus.rsp_data = s0_data;
    end else begin : g_out_sn
        logic [DATA_W-1:0] data_pipe [1:LATENCY-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 1; k < LATENCY; k++) data_pipe[k] <= '0;
            end else if (!stall) begin
                data_pipe[1] <= s0_data;
                for (int k = 2; k < LATENCY; k++) data_pipe[k] <= data_pipe[k-1];
            end
        end
        assign bus.rsp_data = data_pipe[LATENCY-1];
    end
endmodule

// File: tb/tb_imem_pipe.sv
// tb_imem_pipe: directed bench for imem_pipe. Two instances share clock
// and reset: u_l2 (LATENCY=2) and u_l3 (LATENCY=3), both DEPTH=16 and
// preloaded with init_word(i). Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge. With IMEM_WRITE_PORT_EN the
// preload goes through the write port and a strobed-write test is added.
module tb_imem_pipe;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DEP = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_pipe_if #(.ADDR_W(AW), .DATA_W(DW)) b2 ();
    imem_pipe_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

`ifdef IMEM_WRITE_PORT_EN
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_strb;
`endif

    imem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(2), .INIT_FILE("")) u_l2 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef IMEM_WRITE_PORT_EN
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
`endif
        .bus     (b2)
    );

    imem_pipe #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(3), .INIT_FILE("")) u_l3 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef IMEM_WRITE_PORT_EN
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
`endif
        .bus     (b3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h1122_3344 : (32'hC0DE_0000 | 32'(i));
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Check the LATENCY=2 response; data/err only matter when valid.
    task automatic rsp2(input string tag, input logic v, input logic [31:0] d, input logic [1:0] e);
        chk({tag, ".vld"}, b2.rsp_valid, v);
        if (v) begin
            chk({tag, ".data"}, b2.rsp_data, d);
            chk({tag, ".err"}, b2.rsp_err, e);
        end
    endtask

    logic [31:0] e_addr [4] = '{32'h6, 32'h40, 32'h42, 32'h3C};
    logic [1:0]  e_err  [4] = '{2'b01, 2'b10, 2'b01, 2'b00};
    logic [31:0] e_data [4] = '{32'h0, 32'h0, 32'h0, 32'hC0DE_000F};

    initial begin
        b2.req_valid = 1'b0; b2.req_addr = '0; b2.flush = 1'b0; b2.rsp_ready = 1'b1;
        b3.req_valid = 1'b0; b3.req_addr = '0; b3.flush = 1'b0; b3.rsp_ready = 1'b1;
`ifdef IMEM_WRITE_PORT_EN
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
`else
        for (int i = 0; i < DEP; i++) begin
            u_l2.u_bank.mem[i] = init_word(i);
            u_l3.u_bank.mem[i] = init_word(i);
        end
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in.vld", b2.rsp_valid, 1'b0);
        rst_n = 1'b1;
        smp();
        chk("rst.vld",   b2.rsp_valid, 1'b0);
        chk("rst.data",  b2.rsp_data, 32'h0);
        chk("rst.err",   b2.rsp_err, 2'b00);
        chk("rst.rdy",   b2.req_ready, 1'b1);
        chk("rst.rdy3",  b3.req_ready, 1'b1);
        chk("rst.vld3",  b3.rsp_valid, 1'b0);

`ifdef IMEM_WRITE_PORT_EN
        for (int i = 0; i < DEP; i++) begin
            cyc();
            wr_en = 1'b1; wr_addr = 32'(i * 4); wr_data = init_word(i); wr_strb = 4'hF;
        end
        cyc();
        wr_en = 1'b0;
`endif

        // Back-to-back fetch, LATENCY=2
        cyc(); b2.req_valid = 1'b1; b2.req_addr = 32'h0; smp(); chk("b2b.c0", b2.rsp_valid, 1'b0);
        cyc(); b2.req_addr = 32'h4;                      smp(); chk("b2b.c1", b2.rsp_valid, 1'b0);
        cyc(); b2.req_addr = 32'h8;                      smp(); rsp2("b2b.w0", 1'b1, init_word(0), 2'b00);
        cyc(); b2.req_valid = 1'b0;                      smp(); rsp2("b2b.w1", 1'b1, init_word(1), 2'b00);
        cyc();                                           smp(); rsp2("b2b.w2", 1'b1, init_word(2), 2'b00);
        cyc();                                           smp(); chk("b2b.idle", b2.rsp_valid, 1'b0);

        // Backpressure: three stalled cycles with word 1 on the output
        cyc(); b2.req_valid = 1'b1; b2.req_addr = 32'h4; smp();
        cyc(); b2.req_addr = 32'h8;                      smp();
        cyc(); b2.req_addr = 32'hC; b2.rsp_ready = 1'b0; smp();
        rsp2("bp.s0", 1'b1, init_word(1), 2'b00); chk("bp.s0.rdy", b2.req_ready, 1'b0);
        for (int i = 1; i < 3; i++) begin
            cyc(); smp();
            rsp2("bp.hold", 1'b1, init_word(1), 2'b00); chk("bp.hold.rdy", b2.req_ready, 1'b0);
        end
        cyc(); b2.rsp_ready = 1'b1; smp();
        rsp2("bp.rel", 1'b1, init_word(1), 2'b00); chk("bp.rel.rdy", b2.req_ready, 1'b1);
        cyc(); b2.req_valid = 1'b0; smp(); rsp2("bp.w2", 1'b1, init_word(2), 2'b00);
        cyc();                      smp(); rsp2("bp.w3", 1'b1, init_word(3), 2'b00);
        cyc();                      smp(); chk("bp.idle", b2.rsp_valid, 1'b0);

        // Error responses, plus the last in-range word
        for (int c = 0; c < 6; c++) begin
            cyc();
            b2.req_valid = (c < 4);
            if (c < 4) b2.req_addr = e_addr[c];
            smp();
            if (c >= 2) rsp2($sformatf("err.%0h", e_addr[c-2]), 1'b1, e_data[c-2], e_err[c-2]);
        end
        cyc(); smp(); chk("err.idle", b2.rsp_valid, 1'b0);

        // Flush, LATENCY=3
        cyc(); b3.req_valid = 1'b1; b3.req_addr = 32'h0; smp(); chk("fl.c0", b3.rsp_valid, 1'b0);
        cyc(); b3.req_addr = 32'h4;                      smp();
        cyc(); b3.req_addr = 32'h8;                      smp();
        cyc(); b3.req_addr = 32'hC; b3.flush = 1'b1;     smp();
        chk("fl.rdy", b3.req_ready, 1'b0);
        chk("fl.w0.vld", b3.rsp_valid, 1'b1);
        chk("fl.w0.data", b3.rsp_data, init_word(0));
        cyc(); b3.flush = 1'b0; b3.req_valid = 1'b0; smp(); chk("fl.k1", b3.rsp_valid, 1'b0);
        cyc(); smp(); chk("fl.k2", b3.rsp_valid, 1'b0);
        cyc(); smp(); chk("fl.k3", b3.rsp_valid, 1'b0);
        cyc(); b3.req_valid = 1'b1; b3.req_addr = 32'h14; smp(); chk("fl.nx.rdy", b3.req_ready, 1'b1);
        cyc(); b3.req_valid = 1'b0; smp(); chk("fl.nx.c1", b3.rsp_valid, 1'b0);
        cyc(); smp(); chk("fl.nx.c2", b3.rsp_valid, 1'b0);
        cyc(); smp();
        chk("fl.nx.vld", b3.rsp_valid, 1'b1);
        chk("fl.nx.data", b3.rsp_data, init_word(5));
        chk("fl.nx.err", b3.rsp_err, 2'b00);

        // Asynchronous reset with two fetches in flight
        cyc(); b2.req_valid = 1'b1; b2.req_addr = 32'h4; smp();
        cyc(); b2.req_addr = 32'h8;                      smp();
        cyc(); b2.req_valid = 1'b0;                      smp(); rsp2("ar.w1", 1'b1, init_word(1), 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.vld", b2.rsp_valid, 1'b0);
        chk("ar.data", b2.rsp_data, 32'h0);
        cyc(); smp(); chk("ar.hold", b2.rsp_valid, 1'b0);
        #1 rst_n = 1'b1;
        cyc(); b2.req_valid = 1'b1; b2.req_addr = 32'h0; smp(); chk("ar.c0", b2.rsp_valid, 1'b0);
        cyc(); b2.req_valid = 1'b0;                      smp(); chk("ar.c1", b2.rsp_valid, 1'b0);
        cyc();                                           smp(); rsp2("ar.w0", 1'b1, init_word(0), 2'b00);

`ifdef IMEM_WRITE_PORT_EN
        // Strobed write, same-cycle read, ignored misaligned write
        cyc();
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hDEAD_BEEF; wr_strb = 4'b0011;
        b2.req_valid = 1'b1; b2.req_addr = 32'h10;
        smp();
        cyc();
        wr_addr = 32'h12; wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
        b2.req_valid = 1'b0;
        smp();
        cyc(); wr_en = 1'b0; b2.req_valid = 1'b1; b2.req_addr = 32'h10; smp();
        rsp2("wr.old", 1'b1, 32'h1122_3344, 2'b00);
        cyc(); b2.req_valid = 1'b0; smp(); chk("wr.gap", b2.rsp_valid, 1'b0);
        cyc(); smp(); rsp2("wr.new", 1'b1, 32'h1122_BEEF, 2'b00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
